clyde_rcst_sched: RTL and testbench

- Sequencer for the masked Clyde round-constant injection.
- Steps a 4-bit round-constant LFSR forward for encryption or backward for decryption, once per round, and emits each constant as a valid d-share sharing.
- The sharing is non-random: share d-1 carries the bit and shares 0..d-2 are 0.
- Sits beside the masked round datapath and hands it one constant per round through a valid/ready handshake. It also flags step boundaries for tweakey addition.

---
 rtl/clyde_rcst_sched.sv | 91 +++++++++
 tb/tb_clyde_rcst_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clyde_rcst_sched.sv
// clyde_rcst_sched: per-round Clyde constant sequencer emitting a public d-share sharing over valid/ready
module clyde_rcst_sched #(
    parameter int          d        = 2,
    parameter int          NROUNDS  = 12,
    parameter logic [3:0]  INIT_ENC = 4'b0001,
    parameter logic [3:0]  INIT_DEC = 4'b1001
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           start,
    input  logic           inverse,
    input  logic           abort,
    output logic           cst_valid,
    input  logic           cst_ready,
    output logic [4*d-1:0] cst_sh,
    output logic           step_first,
    output logic           last_round,
    output logic           busy,
    output logic           done
);
    localparam int CW = $clog2(NROUNDS + 1);
    localparam logic [CW-1:0] LAST = CW'(NROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state_q, state_d;
    logic [3:0]    lfsr_q, lfsr_d;
    logic [CW-1:0] rnd_q, rnd_d;
    logic          dir_q, dir_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            lfsr_q  <= INIT_ENC;
            rnd_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            rnd_q   <= rnd_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        rnd_d      = rnd_q;
        dir_d      = dir_q;
        cst_valid  = 1'b0;
        cst_sh     = '0;
        step_first = 1'b0;
        last_round = 1'b0;
        done       = 1'b0;
        busy       = state_q != IDLE;
        case (state_q)
            IDLE: if (start) begin
                lfsr_d  = inverse ? INIT_DEC : INIT_ENC;
                dir_d   = inverse;
                rnd_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cst_valid  = 1'b1;
                step_first = ~rnd_q[0];
                last_round = rnd_q == LAST;
                // share d-1 (top of each field) carries the bit, the rest stay zero
                for (int i = 0; i < 4; i++) cst_sh[i*d+d-1] = lfsr_q[i];
                if (cst_ready) begin
                    if (rnd_q == LAST) state_d = FIN;
                    else begin
                        rnd_d  = rnd_q + CW'(1);
                        lfsr_d = dir_q ? {lfsr_q[0] ^ lfsr_q[1], lfsr_q[3:1]}
                                       : {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[0]};
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            rnd_d   = '0;
            lfsr_d  = lfsr_q;
            dir_d   = dir_q;
        end
    end
endmodule

// File: tb/tb_clyde_rcst_sched.sv
// tb_clyde_rcst_sched: scoreboard bench for the round-constant sequencer (d=2 and d=3 instances)
module tb_clyde_rcst_sched;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0, inverse = 1'b0, abort = 1'b0, cst_ready = 1'b0;
    logic        cst_valid, step_first, last_round, busy, done;
    logic [7:0]  cst_sh;
    logic        cst_valid3, step_first3, last_round3, busy3, done3;
    logic [11:0] cst_sh3;

    typedef struct {logic [3:0] w; logic sf; logic lr;} exp_t;
    exp_t q[$];
    logic [3:0] enc_seq [12] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB, 4'h6, 4'hC, 4'h9};

    int checks = 0, errors = 0, pop_cnt = 0;
    logic seen_done = 1'b0, done_exp = 1'b0, stall = 1'b0;
    logic [7:0] prev_sh = '0;

    always #5 clk = ~clk;

    clyde_rcst_sched u_dut (
        .clk(clk), .nrst(nrst), .start(start), .inverse(inverse), .abort(abort),
        .cst_valid(cst_valid), .cst_ready(cst_ready), .cst_sh(cst_sh),
        .step_first(step_first), .last_round(last_round), .busy(busy), .done(done)
    );

    clyde_rcst_sched #(.d(3)) u_dut3 (
        .clk(clk), .nrst(nrst), .start(start), .inverse(inverse), .abort(abort),
        .cst_valid(cst_valid3), .cst_ready(cst_ready), .cst_sh(cst_sh3),
        .step_first(step_first3), .last_round(last_round3), .busy(busy3), .done(done3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] sh2(input logic [3:0] w);
        return {w[3], 1'b0, w[2], 1'b0, w[1], 1'b0, w[0], 1'b0};
    endfunction

    function automatic logic [11:0] sh3(input logic [3:0] w);
        return {w[3], 2'b0, w[2], 2'b0, w[1], 2'b0, w[0], 2'b0};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!nrst) begin
            done_exp = 1'b0;
            stall    = 1'b0;
        end else begin
            chk("done", done, done_exp);
            chk("done3", done3, done_exp);
            if (done) seen_done = 1'b1;
            if (stall) chk("stall_sh", cst_sh, prev_sh);
            chk("valid_pair", cst_valid3, cst_valid);
            done_exp = 1'b0;
            if (cst_valid && cst_ready && !abort) begin
                if (q.size() == 0) chk("sb_empty", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("cst_sh", cst_sh, sh2(e.w));
                    chk("cst_sh3", cst_sh3, sh3(e.w));
                    chk("step_first", step_first, e.sf);
                    chk("last_round", last_round, e.lr);
                    if (e.w == 4'h5) chk("d3_0101", cst_sh3, 12'b000100000100);
                    done_exp = e.lr;
                    pop_cnt++;
                end
            end
            stall   = cst_valid && !cst_ready;
            prev_sh = cst_sh;
        end
    end

    task automatic push_call(input logic inv);
        exp_t e;
        for (int r = 0; r < 12; r++) begin
            e.w  = inv ? enc_seq[11-r] : enc_seq[r];
            e.sf = (r % 2) == 0;
            e.lr = r == 11;
            q.push_back(e);
        end
    endtask

    task automatic begin_call(input logic inv);
        @(posedge clk); #1;
        start = 1'b1; inverse = inv; pop_cnt = 0; seen_done = 1'b0;
        push_call(inv);
        @(posedge clk); #1;
        start = 1'b0; inverse = 1'b0;
        chk("latency", cst_valid, 1);
    endtask

    task automatic run_call(input logic inv, input logic rnd_ready);
        int n;
        begin_call(inv);
        n = 0;
        while (!seen_done && n < 300) begin
            cst_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk("call_timeout", n >= 300, 0);
        chk("busy_idle", busy, 0);
        chk("pops", pop_cnt, 12);
        chk("sb_drained", q.size(), 0);
    endtask

    task automatic wait_pops(input int k);
        int n = 0;
        while (pop_cnt < k && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pop_timeout", n >= 100, 0);
    endtask

    initial begin
        #1;
        chk("rst_valid", cst_valid, 0);
        chk("rst_sh", cst_sh, 0);
        chk("rst_sf", step_first, 0);
        chk("rst_lr", last_round, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #20 nrst = 1'b1;

        run_call(1'b0, 1'b0);
        run_call(1'b1, 1'b0);
        run_call(1'b0, 1'b1);
        run_call(1'b1, 1'b1);

        cst_ready = 1'b1;
        begin_call(1'b0);
        wait_pops(5);
        chk("abort_round", cst_sh, sh2(4'hD));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        q.delete();
        chk("abort_busy", busy, 0);
        chk("abort_valid", cst_valid, 0);
        repeat (3) @(posedge clk);
        #1 chk("abort_nodone", seen_done, 0);
        run_call(1'b0, 1'b0);

        cst_ready = 1'b1;
        begin_call(1'b0);
        wait_pops(3);
        start = 1'b1; inverse = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; inverse = 1'b0;
        wait_pops(7);
        #2 nrst = 1'b0;
        #1;
        chk("arst_valid", cst_valid, 0);
        chk("arst_sh", cst_sh, 0);
        chk("arst_sh3", cst_sh3, 0);
        chk("arst_sf", step_first, 0);
        chk("arst_lr", last_round, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        chk("arst_nodone", seen_done, 0);
        run_call(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
